// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Sequencer state encoding, forwarding mux selects, PC register index.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        ERROR
    } hz_state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;
    localparam logic [3:0] PC_REG = 4'd15;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// clr and inc together restart the count at one.
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] base;

    // Next count: optional clear, then increment unless saturated
    always_comb begin
        base  = clr ? '0 : cnt_q;
        cnt_d = base;
        if (inc && (base != '1)) begin
            cnt_d = base + 1'b1;
        end
    end

    // Count register, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/hazard_controller.sv
// Hazard unit for the 5-stage core: forwarding, load-use stall,
// branch flush, memory-wait freeze and sticky memory timeout.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int REG_AW      = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] RA1D,
    input  logic [REG_AW-1:0] RA2D,
    input  logic [REG_AW-1:0] RA1E,
    input  logic [REG_AW-1:0] RA2E,
    input  logic [REG_AW-1:0] WA3E,
    input  logic [REG_AW-1:0] WA3M,
    input  logic [REG_AW-1:0] WA3W,
    input  logic              MemtoRegE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              BranchTakenE,
    input  logic              MemReqM,
    input  logic              MemReadyM,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushW,
    output logic              MemErr,
    output logic [CNT_W-1:0]  StallCount
);

    localparam logic [REG_AW-1:0] PC = REG_AW'(PC_REG);
    localparam logic [CNT_W-1:0]  TMO = CNT_W'(MEM_TIMEOUT);

    hz_state_t         state_q;
    hz_state_t         state_d;
    logic [CNT_W-1:0]  wait_q;
    logic              wait_clr;
    logic              wait_inc;
    logic              ld_stall;

    // M-stage result beats W-stage; the PC is never forwarded
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] ra,
        input logic              wm,
        input logic [REG_AW-1:0] am,
        input logic              ww,
        input logic [REG_AW-1:0] aw
    );
        if (wm && (ra == am) && (am != PC)) begin
            return FWD_M;
        end else if (ww && (ra == aw) && (aw != PC)) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

    assign ld_stall = MemtoRegE && ((RA1D == WA3E) || (RA2D == WA3E));

    // Combinational stall/flush/forward outputs, all low in reset
    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        if (!reset) begin
            ForwardAE = fwd_sel(RA1E, RegWriteM, WA3M, RegWriteW, WA3W);
            ForwardBE = fwd_sel(RA2E, RegWriteM, WA3M, RegWriteW, WA3W);
            unique case (state_q)
                RUN: begin
                    StallF = ld_stall;
                    StallD = ld_stall;
                    FlushE = ld_stall | BranchTakenE;
                    FlushD = BranchTakenE;
                end
                MEM_WAIT, ERROR: begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                    StallM = 1'b1;
                    FlushW = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Next state and wait-counter control
    always_comb begin
        state_d  = state_q;
        wait_clr = 1'b0;
        wait_inc = 1'b0;
        unique case (state_q)
            RUN: begin
                if (MemReqM && !MemReadyM) begin
                    state_d  = MEM_WAIT;
                    wait_clr = 1'b1;
                    wait_inc = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (MemReadyM) begin
                    state_d = RUN;
                end else if (wait_q == TMO) begin
                    state_d = ERROR;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            ERROR: ;
            default: state_d = RUN;
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign MemErr = (state_q == ERROR);

    sat_counter #(.W(CNT_W)) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (wait_clr),
        .inc   (wait_inc),
        .q     (wait_q)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (StallF),
        .q     (StallCount)
    );

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: vector table, directed
// memory-wait/timeout sequences and random stimulus vs a reference model.
module tb_hazard_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic       MemtoRegE, RegWriteM, RegWriteW, BranchTakenE;
    logic       MemReqM, MemReadyM;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, StallM;
    logic       FlushD, FlushE, FlushW, MemErr;
    logic [3:0] StallCount;

    int checks = 0;
    int errors = 0;

    // reference model: 0 = running, 1 = waiting on memory, 2 = error
    int m_mode;
    int m_wait;
    int m_cnt;

    localparam int TO  = 15;
    localparam int SAT = 15;

    always #5 clk = ~clk;

    hazard_controller #(.REG_AW(4), .MEM_TIMEOUT(15), .CNT_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .RA1D         (RA1D),
        .RA2D         (RA2D),
        .RA1E         (RA1E),
        .RA2E         (RA2E),
        .WA3E         (WA3E),
        .WA3M         (WA3M),
        .WA3W         (WA3W),
        .MemtoRegE    (MemtoRegE),
        .RegWriteM    (RegWriteM),
        .RegWriteW    (RegWriteW),
        .BranchTakenE (BranchTakenE),
        .MemReqM      (MemReqM),
        .MemReadyM    (MemReadyM),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .StallF       (StallF),
        .StallD       (StallD),
        .StallE       (StallE),
        .StallM       (StallM),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .FlushW       (FlushW),
        .MemErr       (MemErr),
        .StallCount   (StallCount)
    );

    typedef struct {
        logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
        logic       ldE, rwM, rwW, br;
        int         fa, fb, sf, fd, fe;
    } vec_t;

    vec_t vt[10];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int mfwd(input logic [3:0] ra);
        if (RegWriteM && ra == WA3M && WA3M != 4'd15) return 2;
        if (RegWriteW && ra == WA3W && WA3W != 4'd15) return 1;
        return 0;
    endfunction

    function automatic int m_ld();
        return (MemtoRegE && (RA1D == WA3E || RA2D == WA3E)) ? 1 : 0;
    endfunction

    function automatic int m_stallf();
        return (m_mode == 0) ? m_ld() : 1;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_wait = 0;
        m_cnt  = 0;
    endtask

    task automatic check_model();
        int ea, eb, sf, fd, fe, se;
        if (reset) begin
            ea = 0; eb = 0; sf = 0; fd = 0; fe = 0; se = 0;
        end else begin
            ea = mfwd(RA1E);
            eb = mfwd(RA2E);
            sf = m_stallf();
            if (m_mode == 0) begin
                fd = BranchTakenE;
                fe = m_ld() | BranchTakenE;
                se = 0;
            end else begin
                fd = 0; fe = 0; se = 1;
            end
        end
        check("ForwardAE", ForwardAE, ea);
        check("ForwardBE", ForwardBE, eb);
        check("StallF", StallF, sf);
        check("StallD", StallD, sf);
        check("StallE", StallE, se);
        check("StallM", StallM, se);
        check("FlushD", FlushD, fd);
        check("FlushE", FlushE, fe);
        check("FlushW", FlushW, se);
        check("MemErr", MemErr, (m_mode == 2) ? 1 : 0);
        check("StallCount", StallCount, m_cnt);
    endtask

    // advance one clock and the model with it; returns on the next negedge
    task automatic tick();
        int sf;
        sf = m_stallf();
        @(posedge clk);
        if (m_cnt + sf <= SAT) m_cnt = m_cnt + sf;
        if (m_mode == 0) begin
            if (MemReqM && !MemReadyM) begin
                m_mode = 1;
                m_wait = 1;
            end
        end else if (m_mode == 1) begin
            if (MemReadyM) m_mode = 0;
            else if (m_wait == TO) m_mode = 2;
            else m_wait++;
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
        {MemtoRegE, RegWriteM, RegWriteW, BranchTakenE} = '0;
        MemReqM   = 1'b0;
        MemReadyM = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_model();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [3:0] pick();
        int r;
        r = $urandom_range(0, 5);
        return (r == 5) ? 4'd15 : 4'(r);
    endfunction

    initial begin
        vt[0] = '{4'd0, 4'd0, 4'd3, 4'd0, 4'd7, 4'd3, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0, 2, 0, 0, 0, 0};
        vt[1] = '{4'd0, 4'd0, 4'd3, 4'd0, 4'd7, 4'd3, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 0, 0, 0};
        vt[2] = '{4'd0, 4'd0, 4'd15, 4'd15, 4'd7, 4'd15, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0};
        vt[3] = '{4'd0, 4'd0, 4'd1, 4'd15, 4'd7, 4'd15, 4'd15, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0};
        vt[4] = '{4'd0, 4'd5, 4'd0, 4'd1, 4'd5, 4'd9, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1, 0, 1};
        vt[5] = '{4'd5, 4'd2, 4'd0, 4'd1, 4'd5, 4'd9, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1, 0, 1};
        vt[6] = '{4'd5, 4'd2, 4'd0, 4'd1, 4'd5, 4'd9, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0};
        vt[7] = '{4'd1, 4'd2, 4'd0, 4'd1, 4'd5, 4'd9, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 1, 1};
        vt[8] = '{4'd1, 4'd2, 4'd4, 4'd2, 4'd5, 4'd2, 4'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1, 2, 0, 0, 0};
        vt[9] = '{4'd6, 4'd2, 4'd0, 4'd1, 4'd6, 4'd9, 4'd9, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1, 1, 1};

        // reset with forwarding-worthy inputs: everything must read zero
        clear_inputs();
        RegWriteM = 1'b1; WA3M = 4'd3; RA1E = 4'd3; BranchTakenE = 1'b1;
        model_reset();
        reset = 1'b1;
        #2;
        check_model();
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();

        // table vectors, all in the running state
        for (int i = 0; i < 10; i++) begin
            RA1D = vt[i].ra1d; RA2D = vt[i].ra2d;
            RA1E = vt[i].ra1e; RA2E = vt[i].ra2e;
            WA3E = vt[i].wa3e; WA3M = vt[i].wa3m; WA3W = vt[i].wa3w;
            MemtoRegE = vt[i].ldE; RegWriteM = vt[i].rwM;
            RegWriteW = vt[i].rwW; BranchTakenE = vt[i].br;
            #1;
            check_model();
            check("vec.ForwardAE", ForwardAE, vt[i].fa);
            check("vec.ForwardBE", ForwardBE, vt[i].fb);
            check("vec.StallF", StallF, vt[i].sf);
            check("vec.FlushD", FlushD, vt[i].fd);
            check("vec.FlushE", FlushE, vt[i].fe);
            check("vec.StallE", StallE, 0);
            tick();
            if (i == 4) check("T3.StallCount", StallCount, 1);
        end

        // branch held in E across a 3-cycle-low memory wait
        do_reset();
        clear_inputs();
        BranchTakenE = 1'b1;
        MemReqM = 1'b1;
        #1; check_model(); tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            check_model();
            check("T5.StallE", StallE, 1);
            check("T5.FlushW", FlushW, 1);
            check("T5.FlushD", FlushD, 0);
            tick();
        end
        MemReadyM = 1'b1;
        #1; check_model(); check("T5.rdy.StallF", StallF, 1); tick();
        MemReqM = 1'b0;
        MemReadyM = 1'b0;
        #1;
        check_model();
        check("T5.run.FlushD", FlushD, 1);
        check("T5.run.FlushE", FlushE, 1);
        check("T5.run.StallE", StallE, 0);
        tick();

        // timeout: 15 wait cycles then sticky error
        do_reset();
        clear_inputs();
        MemReqM = 1'b1;
        #1; check_model(); tick();
        for (int i = 0; i < 15; i++) begin
            #1;
            check_model();
            check("T6.wait.MemErr", MemErr, 0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            MemReadyM = (i == 1);
            #1;
            check_model();
            check("T6.err.MemErr", MemErr, 1);
            check("T6.err.StallM", StallM, 1);
            tick();
        end
        RegWriteM = 1'b1; WA3M = 4'd3; RA1E = 4'd3;
        #2;
        reset = 1'b1;
        #1;
        check("T6.rst.MemErr", MemErr, 0);
        check("T6.rst.StallF", StallF, 0);
        check("T6.rst.ForwardAE", ForwardAE, 0);
        check("T6.rst.StallCount", StallCount, 0);
        model_reset();
        check_model();
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
        BranchTakenE = 1'b1;
        #1;
        check_model();
        check("T6.run.FlushD", FlushD, 1);
        check("T6.run.StallF", StallF, 0);
        tick();

        // random stimulus against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                do_reset();
            end else begin
                RA1D = pick(); RA2D = pick();
                RA1E = pick(); RA2E = pick();
                WA3E = pick(); WA3M = pick(); WA3W = pick();
                MemtoRegE    = 1'($urandom_range(0, 1));
                RegWriteM    = 1'($urandom_range(0, 1));
                RegWriteW    = 1'($urandom_range(0, 1));
                BranchTakenE = ($urandom_range(0, 3) == 0);
                MemReqM      = ($urandom_range(0, 3) == 0);
                MemReadyM    = ($urandom_range(0, 4) == 0);
                #1;
                check_model();
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
